// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard-resolution unit for the five-stage pipeline. Keeps a shadow copy of
//   the register tags and write/load flags for the E, M and W stages and uses it
//   to drive forwarding selects, stall strobes and flush strobes. Also counts
//   load-use stall cycles and branch flush cycles for performance monitoring.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous active-low reset
//   Rs1_D/Rs2_D  source register fields of the Decode instruction
//   Rd_D         destination register field of the Decode instruction
//   RegWrite_D   Decode instruction writes the register file
//   ResultSrc_D  result source; 2'b01 marks a load
//   PCSrc_E      taken branch/jump resolved in Execute
//   cnt_clr      synchronous clear of both counters (wins over increment)
//   Forward_AE   SrcA select: 00 regfile, 10 ALUResult_M, 01 Result_W
//   Forward_BE   SrcB select, same encoding
//   Stall_F      hold PC
//   Stall_D      hold IF/ID
//   Flush_D      clear IF/ID
//   Flush_E      clear ID/EX
//   stall_cnt    saturating count of load-use stall cycles
//   flush_cnt    saturating count of cycles with PCSrc_E asserted
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       ResultSrc_D,
  input  logic             PCSrc_E,
  input  logic             cnt_clr,
  output logic [1:0]       Forward_AE,
  output logic [1:0]       Forward_BE,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Shadow pipeline
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       regwrite_e, load_e;
  logic [4:0] rd_m;
  logic       regwrite_m;
  logic [4:0] rd_w;
  logic       regwrite_w;

  logic       lw_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      load_e     <= 1'b0;
      rd_m       <= '0;
      regwrite_m <= 1'b0;
      rd_w       <= '0;
      regwrite_w <= 1'b0;
    end else begin
      if (Flush_E) begin
        rs1_e      <= '0;
        rs2_e      <= '0;
        rd_e       <= '0;
        regwrite_e <= 1'b0;
        load_e     <= 1'b0;
      end else begin
        rs1_e      <= Rs1_D;
        rs2_e      <= Rs2_D;
        rd_e       <= Rd_D;
        regwrite_e <= RegWrite_D;
        load_e     <= (ResultSrc_D == 2'b01);
      end
      rd_m       <= rd_e;
      regwrite_m <= regwrite_e;
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m;
    end
  end

  // Forwarding: purely from registered shadow state, M has priority over W
  always_comb begin
    Forward_AE = 2'b00;
    if (rs1_e != 5'd0 && rs1_e == rd_m && regwrite_m)
      Forward_AE = 2'b10;
    else if (rs1_e != 5'd0 && rs1_e == rd_w && regwrite_w)
      Forward_AE = 2'b01;
  end

  always_comb begin
    Forward_BE = 2'b00;
    if (rs2_e != 5'd0 && rs2_e == rd_m && regwrite_m)
      Forward_BE = 2'b10;
    else if (rs2_e != 5'd0 && rs2_e == rd_w && regwrite_w)
      Forward_BE = 2'b01;
  end

  always_comb begin
    lw_stall = load_e && (rd_e != 5'd0) && ((Rs1_D == rd_e) || (Rs2_D == rd_e));
    Stall_F  = lw_stall;
    Stall_D  = lw_stall;
    Flush_D  = PCSrc_E;
    // Flush_E is held low while in reset; Flush_D alone tracks PCSrc_E then.
    Flush_E  = reset && (lw_stall || PCSrc_E);
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (PCSrc_E && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1_D, Rs2_D, Rd_D;
  logic        RegWrite_D;
  logic [1:0]  ResultSrc_D;
  logic        PCSrc_E, cnt_clr;

  logic [1:0]  Forward_AE, Forward_BE;
  logic        Stall_F, Stall_D, Flush_D, Flush_E;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_Forward_AE, s_Forward_BE;
  logic        s_Stall_F, s_Stall_D, s_Flush_D, s_Flush_E;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .PCSrc_E(PCSrc_E),
    .cnt_clr(cnt_clr), .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .PCSrc_E(PCSrc_E),
    .cnt_clr(cnt_clr), .Forward_AE(s_Forward_AE), .Forward_BE(s_Forward_BE),
    .Stall_F(s_Stall_F), .Stall_D(s_Stall_D), .Flush_D(s_Flush_D), .Flush_E(s_Flush_E),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Strobe order: {Stall_F, Stall_D, Flush_D, Flush_E}
  task automatic chk_strobes(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, Stall_F, Stall_D, Flush_D, Flush_E}, {28'd0, exp});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk(tag, {28'd0, Forward_AE, Forward_BE}, {28'd0, a, b});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall16"}, {16'd0, stall_cnt}, exp_stall);
    chk({tag, "_flush16"}, {16'd0, flush_cnt}, exp_flush);
    chk({tag, "_stall2"}, {30'd0, s_stall_cnt}, sat3(exp_stall));
    chk({tag, "_flush2"}, {30'd0, s_flush_cnt}, sat3(exp_flush));
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc, input logic pc);
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd;
    RegWrite_D = rw; ResultSrc_D = rsrc; PCSrc_E = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cnt_clr = 1'b0;
    set_d(0, 0, 0, 0, 2'b00, 1'b1);
    chk_strobes("rst_strobes", 4'b0010);
    chk_fwd("rst_fwd", 2'b00, 2'b00);
    tick(); tick();
    chk_cnt("rst_cnt");
    PCSrc_E = 1'b0;
    reset = 1'b1;

    // No producer for x5
    set_d(5, 0, 0, 0, 2'b00, 1'b0);
    tick();
    chk_fwd("idle_fwd", 2'b00, 2'b00);

    // M forward
    set_d(0, 0, 5, 1, 2'b00, 1'b0);
    tick();
    set_d(5, 5, 0, 0, 2'b00, 1'b0);
    chk_strobes("mfwd_strobes", 4'b0000);
    tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_fwd("mfwd", 2'b10, 2'b10);
    tick();

    // W forward
    set_d(0, 0, 7, 1, 2'b00, 1'b0); tick();
    set_d(1, 2, 0, 0, 2'b00, 1'b0); tick();
    set_d(0, 7, 0, 0, 2'b00, 1'b0); tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_fwd("wfwd", 2'b00, 2'b01);

    // Back-to-back producers: M wins
    set_d(0, 0, 7, 1, 2'b00, 1'b0); tick();
    set_d(0, 0, 7, 1, 2'b00, 1'b0); tick();
    set_d(7, 7, 0, 0, 2'b00, 1'b0); tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_fwd("prio_fwd", 2'b10, 2'b10);

    // Non-writing producer does not forward
    set_d(0, 0, 9, 0, 2'b00, 1'b0); tick();
    set_d(9, 0, 0, 0, 2'b00, 1'b0); tick();
    chk_fwd("norw_fwd", 2'b00, 2'b00);

    // Load-use on rs2
    set_d(0, 0, 6, 1, 2'b01, 1'b0);
    chk_strobes("lu_pre", 4'b0000);
    tick();
    set_d(0, 6, 0, 0, 2'b00, 1'b0);
    chk_strobes("lu_stall", 4'b1101);
    tick(); exp_stall++;
    chk_strobes("lu_after", 4'b0000);
    chk_cnt("lu_cnt");
    tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_fwd("lu_wfwd", 2'b00, 2'b01);
    tick();

    // Load to x0: no stall, no forward
    set_d(0, 0, 0, 1, 2'b01, 1'b0); tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_strobes("x0_strobes", 4'b0000);
    tick();
    chk_fwd("x0_fwd", 2'b00, 2'b00);

    // Load-use on rs1
    set_d(0, 0, 4, 1, 2'b01, 1'b0); tick();
    set_d(4, 0, 0, 0, 2'b00, 1'b0);
    chk_strobes("lu1_stall", 4'b1101);
    tick(); exp_stall++;
    tick();

    // Branch flush with producer of x3 in Decode
    set_d(0, 0, 0, 0, 2'b00, 1'b0); tick();
    set_d(0, 0, 3, 1, 2'b00, 1'b1);
    chk_strobes("br_strobes", 4'b0011);
    tick(); exp_flush++;
    set_d(3, 0, 0, 0, 2'b00, 1'b0);
    chk_cnt("br_cnt");
    tick();
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_fwd("br_fwd", 2'b00, 2'b00);

    // Simultaneous load-use and branch
    set_d(0, 0, 12, 1, 2'b01, 1'b0); tick();
    set_d(12, 0, 0, 0, 2'b00, 1'b1);
    chk_strobes("both_strobes", 4'b1111);
    tick(); exp_stall++; exp_flush++;
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_cnt("both_cnt");

    // Drive stall count past 3
    for (int i = 0; i < 2; i++) begin
      set_d(0, 0, 2, 1, 2'b01, 1'b0); tick();
      set_d(2, 0, 0, 0, 2'b00, 1'b0); tick(); exp_stall++;
      set_d(0, 0, 0, 0, 2'b00, 1'b0); tick();
    end
    chk_cnt("stall_sat");

    // Five branch cycles
    for (int i = 0; i < 5; i++) begin
      set_d(0, 0, 0, 0, 2'b00, 1'b1); tick(); exp_flush++;
    end
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_cnt("flush_sat");

    // Clear beats increment
    set_d(0, 0, 0, 0, 2'b00, 1'b1);
    cnt_clr = 1'b1;
    tick(); exp_stall = 0; exp_flush = 0;
    cnt_clr = 1'b0;
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_cnt("clr_cnt");
    set_d(0, 0, 0, 0, 2'b00, 1'b1);
    tick(); exp_flush++;
    set_d(0, 0, 0, 0, 2'b00, 1'b0);
    chk_cnt("post_clr_cnt");

    // Reset mid-operation discards in-flight tags
    set_d(0, 0, 8, 1, 2'b00, 1'b0); tick();
    set_d(0, 0, 8, 1, 2'b01, 1'b0); tick();
    set_d(8, 8, 0, 0, 2'b00, 1'b0);
    chk_strobes("mid_pre", 4'b1101);
    PCSrc_E = 1'b1;
    reset = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    chk_strobes("mid_rst_strobes", 4'b0010);
    chk_fwd("mid_rst_fwd", 2'b00, 2'b00);
    chk_cnt("mid_rst_cnt");
    PCSrc_E = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_strobes("mid_rel_strobes", 4'b0000);
    tick();
    chk_fwd("mid_rel_fwd", 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
